// File: rtl/bfloat16_div_seq.sv
// Sequential bfloat16 divider: radix-2 restoring division, fixed 12-cycle latency.
// Define BFLOAT_DIV_FLAGS_EN to add the invalid/div_by_zero/overflow/underflow outputs.
module bfloat16_div_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
`ifdef BFLOAT_DIV_FLAGS_EN
    output logic         invalid,
    output logic         div_by_zero,
    output logic         overflow,
    output logic         underflow,
`endif
    output logic [W-1:0] out
);

    localparam int SIG_W = MAN_W + 1;
    localparam int ITER  = MAN_W + 3;
    localparam int EW2   = EXP_W + 2;
    localparam int CNT_W = $clog2(ITER);

    localparam logic signed [EW2-1:0] BIAS  = EW2'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW2-1:0] EMAX  = EW2'((1 << EXP_W) - 1);
    localparam logic signed [EW2-1:0] EZERO = '0;
    localparam logic signed [EW2-1:0] EONE  = EW2'(1);
    localparam logic [W-1:0]          QNAN  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]      CNT_INIT = CNT_W'(ITER - 1);

    typedef enum logic [1:0] {IDLE, UNPACK, DIV, ROUND} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;

    logic [W-1:0]       a_p0, b_p0;

    logic               sign_p1;
    logic signed [EW2-1:0] exp_p1;
    logic [SIG_W-1:0]   mb_p1;
    logic               spec_p1;
    logic [W-1:0]       spec_word_p1;

    logic [SIG_W:0]     rem_p2;
    logic [ITER-1:0]    quo_p2;

    logic               sa, sb, sign_c;
    logic [EXP_W-1:0]   ea, eb;
    logic [MAN_W-1:0]   fa, fb;
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic signed [EW2-1:0] exp_c;
    logic               spec_c;
    logic [W-1:0]       spec_word_c;
    logic               div_ge;
    logic [W-1:0]       rnd_word;

`ifdef BFLOAT_DIV_FLAGS_EN
    logic inv_c, dz_c, inv_p1, dz_p1;
`endif

    // Normalise the quotient, round to nearest-even and pack with overflow/flush handling.
    function automatic logic [W-1:0] round_pack(
        input logic                  sgn,
        input logic signed [EW2-1:0] e_in,
        input logic [ITER-1:0]       q,
        input logic                  rem_nz
    );
        logic [MAN_W-1:0]      man;
        logic                  guard, sticky, up, carry;
        logic signed [EW2-1:0] e;
        if (q[ITER-1]) begin
            man    = q[ITER-2 -: MAN_W];
            guard  = q[1];
            sticky = q[0] | rem_nz;
            e      = e_in;
        end else begin
            man    = q[ITER-3 -: MAN_W];
            guard  = q[0];
            sticky = rem_nz;
            e      = e_in - EONE;
        end
        up    = guard & (sticky | man[0]);
        carry = up & (&man);
        man   = man + {{(MAN_W-1){1'b0}}, up};
        if (carry) e = e + EONE;
        if (e >= EMAX)
            round_pack = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (e <= EZERO)
            round_pack = {sgn, {(W-1){1'b0}}};
        else
            round_pack = {sgn, e[EXP_W-1:0], man};
    endfunction

    assign sa = a_p0[W-1];
    assign sb = b_p0[W-1];
    assign ea = a_p0[W-2 -: EXP_W];
    assign eb = b_p0[W-2 -: EXP_W];
    assign fa = a_p0[MAN_W-1:0];
    assign fb = b_p0[MAN_W-1:0];

    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (&ea) && (fa == '0);
    assign b_inf  = (&eb) && (fb == '0);
    assign a_nan  = (&ea) && (fa != '0);
    assign b_nan  = (&eb) && (fb != '0);

    assign sign_c = sa ^ sb;
    assign exp_c  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;

    always_comb begin
        spec_c      = 1'b1;
        spec_word_c = '0;
`ifdef BFLOAT_DIV_FLAGS_EN
        inv_c       = 1'b0;
        dz_c        = 1'b0;
`endif
        if (a_nan || b_nan) begin
            spec_word_c = QNAN;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_word_c = QNAN;
`ifdef BFLOAT_DIV_FLAGS_EN
            inv_c       = 1'b1;
`endif
        end else if (a_inf) begin
            spec_word_c = {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_zero) begin
            spec_word_c = {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`ifdef BFLOAT_DIV_FLAGS_EN
            dz_c        = 1'b1;
`endif
        end else if (b_inf || a_zero) begin
            spec_word_c = {sign_c, {(W-1){1'b0}}};
        end else begin
            spec_c      = 1'b0;
        end
    end

    assign div_ge   = (rem_p2 >= {1'b0, mb_p1});
    assign rnd_word = round_pack(sign_p1, exp_p1, quo_p2, |rem_p2);
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = UNPACK;
            UNPACK:  state_nxt = DIV;
            DIV:     if (cnt == '0) state_nxt = ROUND;
            ROUND:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
            out   <= '0;
`ifdef BFLOAT_DIV_FLAGS_EN
            invalid     <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            done  <= (state == ROUND);
            if (state == UNPACK)
                cnt <= CNT_INIT;
            else if (state == DIV)
                cnt <= cnt - 1'b1;
            if (state == ROUND) begin
                out <= spec_p1 ? spec_word_p1 : rnd_word;
`ifdef BFLOAT_DIV_FLAGS_EN
                invalid     <= spec_p1 & inv_p1;
                div_by_zero <= spec_p1 & dz_p1;
                // The normal path only yields inf on overflow and zero on flush.
                overflow    <= ~spec_p1 & (&rnd_word[W-2 -: EXP_W]);
                underflow   <= ~spec_p1 & ~(|rnd_word[W-2 -: EXP_W]);
`endif
            end
        end
    end

    // Stage p0: operand capture on accept
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            a_p0 <= a;
            b_p0 <= b;
        end
    end

    // Stage p1: unpacked fields and special-case result
    always_ff @(posedge clk) begin
        if (state == UNPACK) begin
            sign_p1      <= sign_c;
            exp_p1       <= exp_c;
            mb_p1        <= {1'b1, fb};
            spec_p1      <= spec_c;
            spec_word_p1 <= spec_word_c;
`ifdef BFLOAT_DIV_FLAGS_EN
            inv_p1       <= inv_c;
            dz_p1        <= dz_c;
`endif
        end
    end

    // Stage p2: restoring division, one quotient bit per cycle
    always_ff @(posedge clk) begin
        if (state == UNPACK) begin
            rem_p2 <= {1'b0, 1'b1, fa};
            quo_p2 <= '0;
        end else if (state == DIV) begin
            rem_p2 <= (div_ge ? rem_p2 - {1'b0, mb_p1} : rem_p2) << 1;
            quo_p2 <= {quo_p2[ITER-2:0], div_ge};
        end
    end

endmodule

// File: doc/bfloat16_div_seq.md
Name: bfloat16_div_seq

Overview:
- Sequential, multi-cycle bfloat16 divider. Computes out = a / b with a radix-2 restoring-division FSM.
- Complements the existing bfloat16 multiply/MAC datapath by providing the inverse operation for normalisation and scaling stages.
- Start/busy/done handshake; one division in flight at a time.
- Fixed latency for every operand pair, including special cases.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 7, stored mantissa field width (hidden bit excluded). Word width W = 1+EXP_W+MAN_W = 16.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- a  input  W  dividend.
- b  input  W  divisor.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse; out is valid from this cycle.
- out  output  W  quotient; held until the next done.

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is synchronous and active-high.
- Reset values: out=0, busy=0, done=0, state=IDLE. Optional flags reset to 0.
- Reset mid-operation abandons the division. The next edge yields the reset values and no done pulse.
- States: IDLE -> UNPACK -> DIV -> ROUND -> IDLE.
- IDLE:
  - start=1 registers a and b (edge E0) and sets busy=1.
  - start while busy=1 is ignored, with no queueing.
  - start may be asserted in the same cycle as done; it is accepted.
- UNPACK, 1 cycle:
  - Split sign, exponent and mantissa; prepend the hidden 1.
  - Subnormal inputs are flushed to signed zero.
  - Classify specials.
  - Compute sign = sa^sb and the exponent e = ea - eb + BIAS (BIAS=127) in EXP_W+2-bit signed arithmetic.
- DIV, ITER = MAN_W+3 = 10 cycles:
  - Counter counts from ITER-1 down to 0.
  - Each cycle: remainder shifted left by 1, compared with the divisor, subtracted if >=, quotient bit shifted in.
  - Quotient lies in (0.5, 2).
- ROUND, 1 cycle:
  - If quotient MSB=0, shift left 1 and decrement e.
  - Sticky bit = OR of the remaining bits and (remainder != 0).
  - Round to nearest, ties to even.
  - A rounding carry renormalises and increments e.
  - After rounding: e >= 255 gives signed inf; e <= 0 gives signed zero (flush).
- Special-case results, still delivered at the fixed latency:
  - Any NaN input: out = 16'h7FC0.
  - 0/0 or inf/inf: out = 7FC0 (invalid).
  - finite/0: signed inf (div_by_zero).
  - inf/finite: signed inf.
  - finite/inf or 0/finite: signed zero.
- Latency: done pulses in the cycle after edge E0+MAN_W+5, i.e. 12 cycles after the accepting edge.
  - busy falls in the same cycle done rises.
  - out updates on the same edge that raises done.

Optional Feature:
- Macro: BFLOAT_DIV_FLAGS_EN.
- Defined: adds output ports invalid, div_by_zero, overflow, underflow (1 bit each).
  - All four are updated on the done edge and held until the next done.
  - overflow: finite operands, rounded result reached inf.
  - underflow: nonzero finite result flushed to zero.
- Undefined: these ports and their logic are absent. out, busy and done behave identically in both builds.

Test Plan:
- a=3F80 (1.0), b=4000 (2.0), start at E0 -> out=3F00, done exactly 12 cycles later, busy high throughout.
- a=3F80, b=4040 (3.0) -> out=3EAB, which checks round-up on guard=1 with sticky=1.
- a=4000, b=0000 -> out=7F80, div_by_zero=1. a=0000, b=0000 -> out=7FC0, invalid=1. Both at 12-cycle latency.
- a=7F00 (2^127), b=3E80 (0.25) -> out=7F80, overflow=1.
- a=0080, b=4400 -> out=0000, underflow=1.
- start re-pulsed with new operands at cycle 5 of a division -> ignored, and the first result is unchanged.
- start on the done cycle -> accepted, and the second done follows 12 cycles later.
- rst asserted at cycle 6 of a division -> next cycle busy=0, out=0, and no done for that operation.
